// File: rtl/fft_pkg.sv
// Shared definitions for the butterfly FFT column datapath.
//   N      : samples per frame (power of two, >= 4)
//   W      : sample width, {real[63:32], imag[31:0]}, IEEE-754 single each
//   LOG2N  : index width into a frame
//   cplx_t : one complex sample as a packed struct
//   bitrev : reverses the LOG2N low bits of a sample index
package fft_pkg;

    localparam int N     = 32;
    localparam int W     = 64;
    localparam int LOG2N = $clog2(N);

    // "real" is a reserved word, hence re/im.
    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
    } cplx_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = k[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_loader_if.sv
// Streaming sample input plus parallel frame output of the FFT frame loader.
//   s_data/s_valid/s_ready       : sample stream, valid/ready handshake
//   frame_data/frame_valid       : flat N*W frame, element i at [i*W +: W]
//   frame_ack                    : single-cycle release of the presented frame
// master = producer/consumer side, slave = the loader.
interface fft_frame_loader_if;
    import fft_pkg::*;

    logic [W-1:0]   s_data;
    logic           s_valid;
    logic           s_ready;
    logic [N*W-1:0] frame_data;
    logic           frame_valid;
    logic           frame_ack;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready,
        input  frame_data,
        input  frame_valid,
        output frame_ack
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready,
        output frame_data,
        output frame_valid,
        input  frame_ack
    );

endinterface

// File: rtl/fft_frame_bank.sv
// One frame bank: N registers of W bits with synchronous reset to zero.
//   clk, reset : clock, synchronous active-high reset
//   wr_en      : write wr_data to element wr_idx this cycle
//   wr_idx     : element index
//   wr_data    : sample to store
//   rd_data    : whole bank as a packed bus, element i at [i*W +: W]
module fft_frame_bank
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [LOG2N-1:0] wr_idx,
    input  logic [W-1:0]     wr_data,
    output logic [N*W-1:0]   rd_data
);

    // Storage lives directly in the packed read bus, one register slice per
    // element, so the read side needs no extra muxing.
    for (genvar i = 0; i < N; i++) begin : g_elem
        always_ff @(posedge clk) begin
            if (reset) begin
                rd_data[i*W +: W] <= '0;
            end else if (wr_en && (wr_idx == LOG2N'(i))) begin
                rd_data[i*W +: W] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/fft_frame_loader.sv
// Ping-pong frame loader: assembles N streamed samples into a frame and
// presents it as a flat parallel bus for the FFT column stage, while the
// next frame loads into the other bank.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fft_frame_loader_if.slave (sample stream in, frame out)
//   BITREV     : 1 = sample k stored at element bitrev(k), 0 = natural order
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter bit BITREV = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    fft_frame_loader_if.slave   bus
);

    logic [1:0]       full;
    logic             wr_bank;
    logic             rd_bank;
    logic [LOG2N-1:0] wr_cnt;

    logic             accept;
    logic             ack;
    logic [LOG2N-1:0] wr_idx;
    logic [N*W-1:0]   bank0_data;
    logic [N*W-1:0]   bank1_data;

    assign accept = bus.s_valid && bus.s_ready;
    assign ack    = bus.frame_ack && bus.frame_valid;
    assign wr_idx = BITREV ? bitrev(wr_cnt) : wr_cnt;

    // Outputs depend only on registers, never on s_valid or frame_ack.
    assign bus.s_ready     = !full[wr_bank];
    assign bus.frame_valid = full[rd_bank];
    assign bus.frame_data  = rd_bank ? bank1_data : bank0_data;

    fft_frame_bank u_bank0 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept && !wr_bank),
        .wr_idx  (wr_idx),
        .wr_data (bus.s_data),
        .rd_data (bank0_data)
    );

    fft_frame_bank u_bank1 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept && wr_bank),
        .wr_idx  (wr_idx),
        .wr_data (bus.s_data),
        .rd_data (bank1_data)
    );

    // A write only ever targets a non-full bank and an ack only a full one,
    // so completing one bank and releasing the other in the same cycle touch
    // different bits of full[] and both take effect.
    always_ff @(posedge clk) begin
        if (reset) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
        end else begin
            if (accept) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_cnt == LOG2N'(N-1)) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end
            if (ack) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Self-checking bench for fft_frame_loader. Two loaders (natural order and
// bit-reversed) receive identical stimulus; a reference model keeps a queue
// of completed frames plus the partially loaded one.
module tb_fft_frame_loader;
    import fft_pkg::*;

    typedef logic [N*W-1:0] frame_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fft_frame_loader_if bus0 ();
    fft_frame_loader_if bus1 ();

    fft_frame_loader #(.BITREV(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    fft_frame_loader #(.BITREV(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    int checks = 0;
    int failures = 0;

    frame_t fq[$];
    frame_t partial = '0;
    int     cnt = 0;

    function automatic int ref_bitrev(input int k);
        int r;
        r = 0;
        for (int b = 0; b < LOG2N; b++) begin
            if (((k >> b) & 1) == 1) r = r | (1 << (LOG2N - 1 - b));
        end
        return r;
    endfunction

    function automatic frame_t permute(input frame_t f);
        frame_t r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            r[ref_bitrev(k)*W +: W] = f[k*W +: W];
        end
        return r;
    endfunction

    // Small non-negative integers to IEEE-754 single.
    function automatic logic [31:0] to_float(input int k, input bit neg);
        logic [31:0] r;
        int e;
        r = '0;
        if (k == 0) return r;
        e = 0;
        for (int b = 0; b < 31; b++) begin
            if (((k >> b) & 1) == 1) e = b;
        end
        r[31]    = neg;
        r[30:23] = 8'(127 + e);
        r[22:0]  = 23'((k << (23 - e)) & 32'h007f_ffff);
        return r;
    endfunction

    function automatic logic [W-1:0] sample(input int k);
        return {to_float(k, 1'b0), to_float(k, 1'b1)};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkState();
        frame_t e;
        logic [N*W-1:0] fd;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("dut%0d s_ready", d),
                        64'(d == 1 ? bus1.s_ready : bus0.s_ready), 64'(fq.size() < 2));
            checkOutput($sformatf("dut%0d frame_valid", d),
                        64'(d == 1 ? bus1.frame_valid : bus0.frame_valid), 64'(fq.size() > 0));
            if (fq.size() > 0) begin
                e  = (d == 1) ? permute(fq[0]) : fq[0];
                fd = (d == 1) ? bus1.frame_data : bus0.frame_data;
                for (int i = 0; i < N; i++) begin
                    checkOutput($sformatf("dut%0d elem%0d", d, i), fd[i*W +: W], e[i*W +: W]);
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [W-1:0] dat, input logic a);
        bit acc;
        bit ack_eff;
        bus0.s_valid = v;  bus1.s_valid = v;
        bus0.s_data = dat; bus1.s_data = dat;
        bus0.frame_ack = a; bus1.frame_ack = a;
        @(posedge clk);
        if (reset) begin
            fq.delete();
            partial = '0;
            cnt = 0;
        end else begin
            acc = v && (fq.size() < 2);
            ack_eff = a && (fq.size() > 0);
            if (ack_eff) void'(fq.pop_front());
            if (acc) begin
                partial[cnt*W +: W] = dat;
                cnt++;
                if (cnt == N) begin
                    fq.push_back(partial);
                    partial = '0;
                    cnt = 0;
                end
            end
        end
        #1;
        checkState();
    endtask

    initial begin
        logic [N*W-1:0] fd;
        bus0.s_valid = 1'b0; bus1.s_valid = 1'b0;
        bus0.s_data = '0;    bus1.s_data = '0;
        bus0.frame_ack = 1'b0; bus1.frame_ack = 1'b0;

        // Reset state
        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        reset = 1'b0;
        fd = bus0.frame_data;
        checkOutput("reset dut0 elem0", fd[0 +: W], '0);
        checkOutput("reset dut0 elem31", fd[31*W +: W], '0);
        fd = bus1.frame_data;
        checkOutput("reset dut1 elem17", fd[17*W +: W], '0);

        // First frame, back-to-back, no ack
        for (int k = 0; k < N; k++) applyStimulus(1'b1, sample(k), 1'b0);
        checkOutput("frame0 valid", 64'(bus0.frame_valid), 64'd1);
        checkOutput("frame0 ready", 64'(bus0.s_ready), 64'd1);

        // Second frame fills bank 1, then stalled offers are dropped
        for (int k = N; k < 2*N; k++) applyStimulus(1'b1, sample(k), 1'b0);
        checkOutput("both full ready", 64'(bus0.s_ready), 64'd0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, {$urandom, $urandom}, 1'b0);
        fd = bus0.frame_data;
        checkOutput("frame0 held elem5", fd[5*W +: W], sample(5));

        // Drain both banks
        applyStimulus(1'b0, '0, 1'b1);
        fd = bus0.frame_data;
        checkOutput("frame1 elem0", fd[0 +: W], sample(N));
        checkOutput("ready after ack", 64'(bus0.s_ready), 64'd1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("empty after 2 acks", 64'(bus0.frame_valid), 64'd0);

        // Complete bank 1 while acking bank 0 in the same cycle
        for (int k = 0; k < 2*N; k++) applyStimulus(1'b1, sample(k + 1), k == 2*N - 1);
        checkOutput("simul valid", 64'(bus0.frame_valid), 64'd1);
        checkOutput("simul ready", 64'(bus0.s_ready), 64'd1);
        fd = bus0.frame_data;
        checkOutput("simul bank1 elem0", fd[0 +: W], sample(N + 1));
        applyStimulus(1'b0, '0, 1'b1);

        // Bit-reversed placement with raw index values
        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < N; k++) applyStimulus(1'b1, 64'(k), 1'b0);
        fd = bus1.frame_data;
        checkOutput("bitrev elem1", fd[1*W +: W], 64'd16);
        checkOutput("bitrev elem2", fd[2*W +: W], 64'd8);
        checkOutput("bitrev elem31", fd[31*W +: W], 64'd31);
        applyStimulus(1'b0, '0, 1'b1);

        // Reset mid-frame discards the partial frame; early ack is ignored
        for (int k = 0; k < 10; k++) applyStimulus(1'b1, {$urandom, $urandom}, 1'b0);
        reset = 1'b1;
        applyStimulus(1'b1, {$urandom, $urandom}, 1'b0);
        reset = 1'b0;
        applyStimulus(1'b0, '0, 1'b1);
        for (int k = 0; k < N; k++) begin
            if (k == N - 1) checkOutput("no early valid", 64'(bus0.frame_valid), 64'd0);
            applyStimulus(1'b1, {$urandom, $urandom}, 1'b0);
        end
        checkOutput("post-reset frame valid", 64'(bus0.frame_valid), 64'd1);
        applyStimulus(1'b0, '0, 1'b1);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            applyStimulus(($urandom % 4) != 0, {$urandom, $urandom}, ($urandom % 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
